// File: rtl/gpu_def.sv
// ---------------------------------------------------------------------------
// gpu_def
// Shared definitions between the scheduler and the per-core receive stage:
// message-bus width, frame geometry and the receive FSM state encoding.
// ---------------------------------------------------------------------------
package gpu_def;

   // Message bus and frame geometry shared with the scheduler
   localparam int GPU_CORE_NUM    = 16;
   localparam int GPU_BUS_TO_CORE = 16;
   localparam int GPU_FRAME_SIZE  = 16;
   localparam int GPU_R0_DEPTH    = 8;

   // Receive-stage FSM states
   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_SEL       = 3'd1,
      RX_LOAD_R0   = 3'd2,
      RX_LOAD_IF   = 3'd3,
      RX_FRAME_RDY = 3'd4
   } rx_state_t;

endpackage

// File: rtl/rx_word_buf.sv
// ---------------------------------------------------------------------------
// rx_word_buf
// DEPTH x WIDTH word buffer filled through an internal write counter that
// wraps after the last slot. 'done' is a combinational pulse on the write
// that fills the last slot. Storage is not reset.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset (counter only)
//   clear          : return the write counter to slot 0
//   wr_en, wr_data : write wr_data into the current slot and advance
//   buf_data       : whole buffer flattened, slot 0 in the LSBs
//   done           : high when this write fills slot DEPTH-1
// ---------------------------------------------------------------------------
module rx_word_buf #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [DEPTH*WIDTH-1:0]   buf_data,
   output logic                     done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH];

   assign done = wr_en && (cnt == LAST);

   // Write counter: wraps to slot 0 once the last slot has been written
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (wr_en) begin
         cnt <= done ? '0 : cnt + 1'b1;
      end
   end

   // Storage has no reset; writes are suppressed while reset is held so an
   // aborted load leaves the buffer contents untouched
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[cnt] <= wr_data;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign buf_data[i*WIDTH +: WIDTH] = mem[i];
   end

endmodule

// File: rtl/core_msg_rx.sv
// ---------------------------------------------------------------------------
// core_msg_rx
// Per-core receive stage on the scheduler's broadcast message bus. Decodes
// the core-select and r0-select masks, captures r0 data and instruction
// frames into local buffers, offers complete frames to fetch through a
// frame_valid/frame_take handshake and reports core_ready to the scheduler.
//
// Optional feature macro: CORE_RX_ERR_EN
//   defined   : err_overflow / err_proto are sticky flags cleared by reset
//   undefined : both error outputs are tied to 0
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mess_to_core          : broadcast message word
//   core_mask_loading     : word is the core-select mask
//   r0_mask_loading       : word is the r0-select mask
//   r0_loading            : word is r0 data
//   if_loading            : word is an instruction word
//   frame_take            : fetch has consumed the held frame
//   instr_rd_addr         : instruction buffer read address
//   instr_rd_data         : combinational instruction buffer read
//   r0_data               : r0 buffer, word 0 in the LSBs
//   r0_valid              : all r0 words of the task captured
//   frame_valid           : a complete instruction frame is held
//   core_ready            : core can accept work
//   err_overflow          : word arrived while a frame was held
//   err_proto             : multiple strobes, or mask word aborted a load
// ---------------------------------------------------------------------------
module core_msg_rx
   import gpu_def::*;
#(
   parameter int CORE_ID     = 0,
   parameter int CORE_NUM    = GPU_CORE_NUM,
   parameter int BUS_TO_CORE = GPU_BUS_TO_CORE,
   parameter int FRAME_SIZE  = GPU_FRAME_SIZE,
   parameter int R0_DEPTH    = GPU_R0_DEPTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [BUS_TO_CORE-1:0]          mess_to_core,
   input  logic                            core_mask_loading,
   input  logic                            r0_mask_loading,
   input  logic                            r0_loading,
   input  logic                            if_loading,
   input  logic                            frame_take,
   input  logic [$clog2(FRAME_SIZE)-1:0]   instr_rd_addr,
   output logic [BUS_TO_CORE-1:0]          instr_rd_data,
   output logic [R0_DEPTH*BUS_TO_CORE-1:0] r0_data,
   output logic                            r0_valid,
   output logic                            frame_valid,
   output logic                            core_ready,
   output logic                            err_overflow,
   output logic                            err_proto
);

   rx_state_t state, state_n;

   logic                   sel;
   logic                   r0_sel;
   logic                   r0_valid_q;
   logic [2:0]             strobe_cnt;
   logic                   multi;
   logic                   cm_word;
   logic                   r0m_word;
   logic                   r0_word;
   logic                   if_word;
   logic [CORE_NUM-1:0]    mask_bits;
   logic                   mask_bit;
   logic                   r0_wr;
   logic                   if_wr;
   logic                   r0_done;
   logic                   if_done;
   logic [FRAME_SIZE*BUS_TO_CORE-1:0] ibuf_data;

   // Strobe decode: a word carrying more than one strobe is ignored
   // entirely. Instruction words are taken in FRAME_RDY only when the held
   // frame is released in the same cycle, which lets back-to-back frames run
   // without a bubble.
   always_comb begin
      strobe_cnt = {2'b00, core_mask_loading} + {2'b00, r0_mask_loading}
                 + {2'b00, r0_loading} + {2'b00, if_loading};
      multi      = (strobe_cnt > 3'd1);
      cm_word    = core_mask_loading && !multi;
      r0m_word   = r0_mask_loading && !multi;
      r0_word    = r0_loading && !multi;
      if_word    = if_loading && !multi;
      mask_bits  = mess_to_core[CORE_NUM-1:0];
      mask_bit   = mask_bits[CORE_ID];
      r0_wr      = r0_word && sel && r0_sel;
      if_wr      = if_word && sel && ((state != RX_FRAME_RDY) || frame_take);
   end

   rx_word_buf #(
      .DEPTH (R0_DEPTH),
      .WIDTH (BUS_TO_CORE)
   ) u_r0_buf (
      .clk      (clk),
      .reset    (reset),
      .clear    (cm_word),
      .wr_en    (r0_wr),
      .wr_data  (mess_to_core),
      .buf_data (r0_data),
      .done     (r0_done)
   );

   rx_word_buf #(
      .DEPTH (FRAME_SIZE),
      .WIDTH (BUS_TO_CORE)
   ) u_if_buf (
      .clk      (clk),
      .reset    (reset),
      .clear    (cm_word),
      .wr_en    (if_wr),
      .wr_data  (mess_to_core),
      .buf_data (ibuf_data),
      .done     (if_done)
   );

   assign instr_rd_data = ibuf_data[instr_rd_addr*BUS_TO_CORE +: BUS_TO_CORE];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RX_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic. A core mask word always wins and re-selects the core,
   // discarding any partial load. Instruction loading takes precedence over
   // r0 loading for the purpose of core_ready.
   always_comb begin
      state_n = state;
      if (cm_word) begin
         state_n = mask_bit ? RX_SEL : RX_IDLE;
      end else begin
         case (state)
            RX_SEL: begin
               if (if_wr) begin
                  state_n = if_done ? RX_FRAME_RDY : RX_LOAD_IF;
               end else if (r0_wr) begin
                  state_n = r0_done ? RX_SEL : RX_LOAD_R0;
               end
            end
            RX_LOAD_R0: begin
               if (if_wr) begin
                  state_n = if_done ? RX_FRAME_RDY : RX_LOAD_IF;
               end else if (r0_done) begin
                  state_n = RX_SEL;
               end
            end
            RX_LOAD_IF: begin
               if (if_done) begin
                  state_n = RX_FRAME_RDY;
               end
            end
            RX_FRAME_RDY: begin
               if (frame_take) begin
                  if (if_wr) begin
                     state_n = if_done ? RX_FRAME_RDY : RX_LOAD_IF;
                  end else begin
                     state_n = RX_SEL;
                  end
               end
            end
            default: state_n = state;
         endcase
      end
   end

   assign frame_valid = (state == RX_FRAME_RDY);
   assign core_ready  = (state == RX_IDLE) || (state == RX_SEL);
   assign r0_valid    = r0_valid_q;

   // Select flags and r0 completion; r0_valid holds until the next task's
   // core mask word
   always_ff @(posedge clk) begin
      if (reset) begin
         sel        <= 1'b0;
         r0_sel     <= 1'b0;
         r0_valid_q <= 1'b0;
      end else begin
         if (cm_word) begin
            sel        <= mask_bit;
            r0_valid_q <= 1'b0;
         end else if (r0_done) begin
            r0_valid_q <= 1'b1;
         end
         if (r0m_word) begin
            r0_sel <= mask_bit;
         end
      end
   end

`ifdef CORE_RX_ERR_EN
   logic err_overflow_q;
   logic err_proto_q;
   logic overflow_set;
   logic proto_set;

   always_comb begin
      overflow_set = if_word && sel && (state == RX_FRAME_RDY) && !frame_take;
      proto_set    = multi ||
                     (cm_word && ((state == RX_LOAD_R0) || (state == RX_LOAD_IF)));
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         err_overflow_q <= 1'b0;
         err_proto_q    <= 1'b0;
      end else begin
         if (overflow_set) begin
            err_overflow_q <= 1'b1;
         end
         if (proto_set) begin
            err_proto_q <= 1'b1;
         end
      end
   end

   assign err_overflow = err_overflow_q;
   assign err_proto    = err_proto_q;
`else
   assign err_overflow = 1'b0;
   assign err_proto    = 1'b0;
`endif

endmodule

// File: tb/tb_core_msg_rx.sv
// ---------------------------------------------------------------------------
// tb_core_msg_rx
// Directed bench for core_msg_rx: one instance as core 2 and one as core 3
// share the same broadcast bus.
// ---------------------------------------------------------------------------
module tb_core_msg_rx;

   localparam logic [3:0] S_NONE = 4'b0000;
   localparam logic [3:0] S_CM   = 4'b1000;
   localparam logic [3:0] S_R0M  = 4'b0100;
   localparam logic [3:0] S_R0   = 4'b0010;
   localparam logic [3:0] S_IF   = 4'b0001;

`ifdef CORE_RX_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [15:0]  mess_to_core = '0;
   logic         core_mask_loading = 1'b0;
   logic         r0_mask_loading = 1'b0;
   logic         r0_loading = 1'b0;
   logic         if_loading = 1'b0;
   logic         frame_take = 1'b0;
   logic [3:0]   instr_rd_addr = '0;

   logic [15:0]  instr_rd_data, instr_rd_data3;
   logic [127:0] r0_data, r0_data3;
   logic         r0_valid, r0_valid3;
   logic         frame_valid, frame_valid3;
   logic         core_ready, core_ready3;
   logic         err_overflow, err_overflow3;
   logic         err_proto, err_proto3;

   int numChecks = 0;
   int numFails  = 0;

   core_msg_rx #(.CORE_ID(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .mess_to_core      (mess_to_core),
      .core_mask_loading (core_mask_loading),
      .r0_mask_loading   (r0_mask_loading),
      .r0_loading        (r0_loading),
      .if_loading        (if_loading),
      .frame_take        (frame_take),
      .instr_rd_addr     (instr_rd_addr),
      .instr_rd_data     (instr_rd_data),
      .r0_data           (r0_data),
      .r0_valid          (r0_valid),
      .frame_valid       (frame_valid),
      .core_ready        (core_ready),
      .err_overflow      (err_overflow),
      .err_proto         (err_proto)
   );

   core_msg_rx #(.CORE_ID(3)) dut3 (
      .clk               (clk),
      .reset             (reset),
      .mess_to_core      (mess_to_core),
      .core_mask_loading (core_mask_loading),
      .r0_mask_loading   (r0_mask_loading),
      .r0_loading        (r0_loading),
      .if_loading        (if_loading),
      .frame_take        (frame_take),
      .instr_rd_addr     (instr_rd_addr),
      .instr_rd_data     (instr_rd_data3),
      .r0_data           (r0_data3),
      .r0_valid          (r0_valid3),
      .frame_valid       (frame_valid3),
      .core_ready        (core_ready3),
      .err_overflow      (err_overflow3),
      .err_proto         (err_proto3)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "[TB] time limit reached");
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [127:0] got,
                              input logic [127:0] exp);
      numChecks++;
      if (got !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one bus word with the given strobes for one clock, then return
   // #1 after the sampling edge with strobes released
   task automatic applyStimulus(input logic [3:0] strobes, input logic [15:0] word,
                                input logic take);
      {core_mask_loading, r0_mask_loading, r0_loading, if_loading} = strobes;
      mess_to_core = word;
      frame_take   = take;
      @(posedge clk);
      #1;
      {core_mask_loading, r0_mask_loading, r0_loading, if_loading} = S_NONE;
      frame_take = 1'b0;
   endtask

   task automatic readInstr(input string tag, input logic [3:0] addr,
                            input logic [15:0] exp);
      instr_rd_addr = addr;
      #1;
      checkOutput(tag, {112'd0, instr_rd_data}, {112'd0, exp});
   endtask

   initial begin
      $display("[TB] start");
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      checkOutput("rst_frame_valid", {127'd0, frame_valid}, 128'd0);
      checkOutput("rst_r0_valid",    {127'd0, r0_valid},    128'd0);
      checkOutput("rst_core_ready",  {127'd0, core_ready},  128'd1);
      checkOutput("rst_err_ovf",     {127'd0, err_overflow}, 128'd0);
      checkOutput("rst_err_proto",   {127'd0, err_proto},   128'd0);

      // Select core 2 and load one full frame
      applyStimulus(S_CM, 16'h0004, 1'b0);
      checkOutput("sel_core_ready", {127'd0, core_ready}, 128'd1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(S_IF, 16'h1000 + 16'(i), 1'b0);
         checkOutput("load_core_ready", {127'd0, core_ready}, 128'd0);
         checkOutput("load_frame_valid", {127'd0, frame_valid}, (i == 15) ? 128'd1 : 128'd0);
      end
      readInstr("rd_addr5",  4'd5,  16'h1005);
      readInstr("rd_addr0",  4'd0,  16'h1000);
      readInstr("rd_addr15", 4'd15, 16'h100F);
      checkOutput("c3_frame_valid", {127'd0, frame_valid3}, 128'd0);
      checkOutput("c3_core_ready",  {127'd0, core_ready3},  128'd1);

      // 17th word while the frame is held and not taken: dropped
      applyStimulus(S_IF, 16'hDEAD, 1'b0);
      checkOutput("ovf_frame_valid", {127'd0, frame_valid}, 128'd1);
      checkOutput("ovf_err",         {127'd0, err_overflow}, {127'd0, ERR_ON});
      checkOutput("ovf_core_ready",  {127'd0, core_ready}, 128'd0);
      readInstr("ovf_ibuf0", 4'd0, 16'h1000);
      checkOutput("c3_ovf_err", {127'd0, err_overflow3}, 128'd0);

      // Take coincident with word 0 of the next frame
      applyStimulus(S_IF, 16'h2000, 1'b1);
      checkOutput("tk_frame_valid", {127'd0, frame_valid}, 128'd0);
      checkOutput("tk_core_ready",  {127'd0, core_ready}, 128'd0);
      readInstr("tk_ibuf0", 4'd0, 16'h2000);
      readInstr("tk_ibuf1", 4'd1, 16'h1001);
      for (int i = 1; i < 16; i++) begin
         applyStimulus(S_IF, 16'h2000 + 16'(i), 1'b0);
         checkOutput("tk2_frame_valid", {127'd0, frame_valid}, (i == 15) ? 128'd1 : 128'd0);
      end
      readInstr("tk2_ibuf15", 4'd15, 16'h200F);
      readInstr("tk2_ibuf7",  4'd7,  16'h2007);

      // Plain take, then a take with nothing held
      applyStimulus(S_NONE, 16'h0000, 1'b1);
      checkOutput("take_frame_valid", {127'd0, frame_valid}, 128'd0);
      checkOutput("take_core_ready",  {127'd0, core_ready}, 128'd1);
      applyStimulus(S_NONE, 16'h0000, 1'b1);
      checkOutput("take_empty_fv", {127'd0, frame_valid}, 128'd0);
      checkOutput("take_empty_cr", {127'd0, core_ready}, 128'd1);

      // r0 load: core mask, r0 mask, 8 data words
      applyStimulus(S_CM,  16'h0004, 1'b0);
      applyStimulus(S_R0M, 16'h0004, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(S_R0, 16'h00A0 + 16'(i), 1'b0);
         checkOutput("r0_valid", {127'd0, r0_valid}, (i == 7) ? 128'd1 : 128'd0);
         checkOutput("r0_core_ready", {127'd0, core_ready}, (i == 7) ? 128'd1 : 128'd0);
      end
      checkOutput("r0_word0", {112'd0, r0_data[15:0]},    128'h00A0);
      checkOutput("r0_word7", {112'd0, r0_data[127:112]}, 128'h00A7);
      checkOutput("r0_word3", {112'd0, r0_data[63:48]},   128'h00A3);
      checkOutput("c3_r0_valid", {127'd0, r0_valid3}, 128'd0);

      // r0 mask deselects core 2: further r0 words ignored
      applyStimulus(S_CM,  16'h0004, 1'b0);
      checkOutput("r0_valid_clr", {127'd0, r0_valid}, 128'd0);
      applyStimulus(S_R0M, 16'h0008, 1'b0);
      applyStimulus(S_R0,  16'h00B0, 1'b0);
      checkOutput("r0_ign_ready", {127'd0, core_ready}, 128'd1);
      checkOutput("r0_ign_data",  {112'd0, r0_data[15:0]}, 128'h00A0);

      // Core mask after 7 instruction words aborts the partial frame
      checkOutput("pre_proto", {127'd0, err_proto}, 128'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(S_IF, 16'h3000 + 16'(i), 1'b0);
      end
      applyStimulus(S_CM, 16'h0004, 1'b0);
      checkOutput("abort_err_proto",   {127'd0, err_proto}, {127'd0, ERR_ON});
      checkOutput("abort_core_ready",  {127'd0, core_ready}, 128'd1);
      checkOutput("abort_frame_valid", {127'd0, frame_valid}, 128'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(S_IF, 16'h4000 + 16'(i), 1'b0);
      end
      checkOutput("reload_frame_valid", {127'd0, frame_valid}, 128'd1);
      readInstr("reload_ibuf0",  4'd0,  16'h4000);
      readInstr("reload_ibuf6",  4'd6,  16'h4006);
      readInstr("reload_ibuf15", 4'd15, 16'h400F);
      applyStimulus(S_NONE, 16'h0000, 1'b1);

      // Two strobes at once: word ignored
      applyStimulus(S_R0 | S_IF, 16'h5555, 1'b0);
      checkOutput("multi_core_ready", {127'd0, core_ready}, 128'd1);
      checkOutput("multi_c3_proto",   {127'd0, err_proto3}, {127'd0, ERR_ON});

      // Reset in the middle of a load: aborted, no error left behind
      for (int i = 0; i < 3; i++) begin
         applyStimulus(S_IF, 16'h6000 + 16'(i), 1'b0);
      end
      checkOutput("midload_core_ready", {127'd0, core_ready}, 128'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rst2_core_ready",  {127'd0, core_ready}, 128'd1);
      checkOutput("rst2_frame_valid", {127'd0, frame_valid}, 128'd0);
      checkOutput("rst2_err_proto",   {127'd0, err_proto}, 128'd0);
      checkOutput("rst2_err_ovf",     {127'd0, err_overflow}, 128'd0);
      applyStimulus(S_IF, 16'h7000, 1'b0);
      checkOutput("rst2_desel", {127'd0, core_ready}, 128'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
